// File: rtl/irq_event_queue.sv
// Interrupt aggregator: per-source pending slots, fixed-priority arbiter, DEPTH-entry FIFO.
// Optional saturating drop counter is built when IRQQ_DROP_COUNT_EN is defined.
module irq_event_queue #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      irq,
  output logic [DATA_W-1:0]         irq_data,
  output logic [SRC_W-1:0]          irq_src,
  input  logic                      irq_ack,
  input  logic                      ovf_clr,
  output logic [NUM_SRC-1:0]        ovf,
  output logic [7:0]                drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = SRC_W + DATA_W;

  logic [NUM_SRC-1:0] r_pend;
  logic [DATA_W-1:0]  r_pend_data [NUM_SRC];
  logic [EW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [NUM_SRC-1:0] r_ovf;

  logic [SRC_W-1:0]   w_sel;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_any;
  logic [NUM_SRC-1:0] w_lowest;
  logic [NUM_SRC-1:0] w_drain;
  logic [NUM_SRC-1:0] w_drop;
  logic [NUM_SRC-1:0] w_load;
  logic               w_pop;
  logic               w_push;
  logic               w_can_accept;
  logic [EW-1:0]      w_head;

  // irq is a level valid for the head entry; irq_ack pops it only while irq is high,
  // and an ack seen while the queue is empty has no effect.
  assign w_pop        = irq_ack && (r_count != '0);
  assign w_can_accept = (r_count != CW'(DEPTH)) || w_pop;

  always_comb begin
    w_sel      = '0;
    w_sel_data = '0;
    w_any      = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel      = SRC_W'(i);
        w_sel_data = r_pend_data[i];
        w_any      = 1'b1;
      end
    end
  end

  assign w_lowest = r_pend & (~r_pend + NUM_SRC'(1));
  assign w_push   = w_any && w_can_accept;
  assign w_drain  = w_push ? w_lowest : '0;
  // A slot being drained this cycle can take a new event without loss.
  assign w_drop   = src_valid & r_pend & ~w_drain;
  assign w_load   = src_valid & ~w_drop;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_pend_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_load[i]) begin
          r_pend[i]      <= 1'b1;
          r_pend_data[i] <= src_data[i*DATA_W +: DATA_W];
        end else if (w_drain[i]) begin
          r_pend[i] <= 1'b0;
        end
        if (w_drop[i])    r_ovf[i] <= 1'b1;
        else if (ovf_clr) r_ovf[i] <= 1'b0;
      end
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wptr] <= {w_sel, w_sel_data};
  end

  assign w_head   = r_mem[r_rptr];
  assign irq      = (r_count != '0);
  assign irq_data = irq ? w_head[DATA_W-1:0] : '0;
  assign irq_src  = irq ? w_head[DATA_W +: SRC_W] : '0;
  assign ovf      = r_ovf;

`ifdef IRQQ_DROP_COUNT_EN
  logic [7:0] r_drop_cnt;
  logic [7:0] w_ndrop;
  logic [8:0] w_drop_sum;

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NUM_SRC; i++) w_ndrop = w_ndrop + 8'(w_drop[i]);
    w_drop_sum = {1'b0, (ovf_clr ? 8'd0 : r_drop_cnt)} + {1'b0, w_ndrop};
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_drop_cnt <= '0;
    else        r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_irq_event_queue.sv
// Directed bench for irq_event_queue (NUM_SRC=2, DATA_W=32, DEPTH=4) with a popped-head scoreboard.
module tb_irq_event_queue;

  localparam int EW = 33;
`ifdef IRQQ_DROP_COUNT_EN
  localparam int DC_ON = 1;
`else
  localparam int DC_ON = 0;
`endif

  logic        sys_clk;
  logic        rst_n;
  logic [1:0]  src_valid;
  logic [63:0] src_data;
  logic        irq;
  logic [31:0] irq_data;
  logic [0:0]  irq_src;
  logic        irq_ack;
  logic        ovf_clr;
  logic [1:0]  ovf;
  logic [7:0]  drop_cnt;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  irq_event_queue #(.NUM_SRC(2), .DATA_W(32), .DEPTH(4)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .src_valid(src_valid),
    .src_data (src_data),
    .irq      (irq),
    .irq_data (irq_data),
    .irq_src  (irq_src),
    .irq_ack  (irq_ack),
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  // clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: entered and left on a falling edge
  task automatic send(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
    src_valid = v;
    src_data  = {d1, d0};
    @(negedge sys_clk);
    src_valid = 2'b00;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    @(negedge sys_clk);
    irq_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_exp(input logic src, input logic [31:0] d);
    exp_q.push_back({src, d});
  endtask

  // monitor: compares the head on every accepted pop
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge sys_clk);
      #2;
      if (rst_n && irq_ack && irq) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected none", {irq_src, irq_data});
        end else begin
          e = exp_q.pop_front();
          chk("pop_head", {31'd0, irq_src, irq_data}, {31'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; src_valid = '0; src_data = '0; irq_ack = 1'b0; ovf_clr = 1'b0;
    idle(3);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;
    idle(1);
    chk("rst_irq_after", irq, 0);
    chk("rst_data", irq_data, 0);
    chk("rst_src", irq_src, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // single event, two-cycle latency
    send(2'b01, 32'd104, 32'd0);
    push_exp(1'b0, 32'd104);
    chk("single_latency", irq, 0);
    idle(1);
    chk("single_irq", irq, 1);
    chk("single_data", irq_data, 104);
    chk("single_src", irq_src, 0);
    ack();
    chk("single_empty", irq, 0);

    // simultaneous events drain in ascending source order
    send(2'b11, 32'd103, 32'hDEAD);
    push_exp(1'b0, 32'd103);
    push_exp(1'b1, 32'hDEAD);
    idle(2);
    chk("simul_head0", {irq_src, irq_data}, {1'b0, 32'd103});
    ack();
    chk("simul_head1", {irq_src, irq_data}, {1'b1, 32'hDEAD});
    ack();
    chk("simul_empty", irq, 0);
    chk("simul_ovf", ovf, 0);

    // six events from source 0 with no acks
    for (int k = 1; k <= 6; k++) begin
      send(2'b01, 32'd200 + 32'(k), 32'd0);
      if (k <= 5) push_exp(1'b0, 32'd200 + 32'(k));
      idle(1);
    end
    chk("full_count", dut.r_count, 4);
    chk("full_pend", dut.r_pend, 2'b01);
    chk("full_ovf", ovf, 2'b01);
    chk("full_drop_cnt", drop_cnt, DC_ON);
    chk("full_head", {irq_src, irq_data}, {1'b0, 32'd201});
    ack();
    chk("refill_count", dut.r_count, 4);
    chk("refill_pend", dut.r_pend, 2'b00);

    // pending event pushed in the same cycle a full FIFO pops
    send(2'b10, 32'd0, 32'h55);
    push_exp(1'b1, 32'h55);
    chk("pp_held", dut.r_pend, 2'b10);
    ack();
    chk("pp_count", dut.r_count, 4);
    chk("pp_pend", dut.r_pend, 2'b00);
    chk("pp_ovf", ovf, 2'b01);
    chk("pp_drop_cnt", drop_cnt, DC_ON);
    repeat (4) ack();
    chk("drain_irq", irq, 0);
    chk("drain_data", irq_data, 0);
    chk("drain_src", irq_src, 0);
    ack();
    chk("ack_empty_count", dut.r_count, 0);

    // overflow clear, then a drop coincident with clear
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    for (int k = 1; k <= 5; k++) begin
      send(2'b10, 32'd0, 32'h100 + 32'(k));
      push_exp(1'b1, 32'h100 + 32'(k));
      idle(1);
    end
    ovf_clr = 1'b1;
    send(2'b10, 32'd0, 32'h1FF);
    ovf_clr = 1'b0;
    chk("clr_drop_wins", ovf, 2'b10);
    chk("clr_drop_cnt2", drop_cnt, DC_ON);
    ack();
    ack();
    chk("pre_rst_count", dut.r_count, 3);
    chk("pre_rst_irq", irq, 1);

    // asynchronous reset with entries queued
    rst_n = 1'b0;
    #1;
    chk("async_rst_irq", irq, 0);
    chk("async_rst_data", irq_data, 0);
    chk("async_rst_ovf", ovf, 0);
    chk("async_rst_drop", drop_cnt, 0);
    exp_q.delete();
    @(negedge sys_clk);
    rst_n = 1'b1;
    idle(1);

    // recovery after reset
    send(2'b01, 32'h77, 32'd0);
    push_exp(1'b0, 32'h77);
    idle(1);
    chk("recover_head", {irq_src, irq_data}, {1'b0, 32'h77});
    ack();
    chk("recover_empty", irq, 0);
    idle(1);
    chk("exp_q_drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_event_queue.md
# irq_event_queue

Parametrised interrupt aggregator between event-producing peripherals (keyboard decoder, network/SPART receiver, future sources) and the processor's interrupt input. It captures single-cycle event pulses with their 32-bit payloads from `NUM_SRC` sources and arbitrates them by fixed priority into a `DEPTH`-entry FIFO. It presents the FIFO head as a level interrupt with data and source ID, which the processor pops with an acknowledge pulse. No event is lost on simultaneous arrival, and every genuine loss is flagged.

## Interface
- `NUM_SRC`, 2: number of event sources, 1..16.
- `DATA_W`, 32: payload width.
- `DEPTH`, 4: FIFO entries, power of two, 2..64.
- `SRC_W`, derived as max(1, clog2(NUM_SRC)): source-ID width. Not user-set.

- `sys_clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `src_valid`  in  NUM_SRC  one-cycle event pulse per source.
- `src_data`  in  NUM_SRC*DATA_W  payloads; source i occupies bits [i*DATA_W +: DATA_W].
- `irq`  out  1  high while the FIFO is non-empty.
- `irq_data`  out  DATA_W  head payload; 0 when empty.
- `irq_src`  out  SRC_W  head source index; 0 when empty.
- `irq_ack`  in  1  one-cycle pop of the head.
- `ovf_clr`  in  1  clears the sticky overflow flags.
- `ovf`  out  NUM_SRC  sticky per-source drop flag.
- `drop_cnt`  out  8  saturating total drop count (see Configuration).

## Operation
- **Capture stage.** Each source has one pending slot (`pend[i]`, `pend_data[i]`).
  - `src_valid[i]` with the slot free, or with the slot being drained this cycle: load the payload and set `pend[i]`.
  - `src_valid[i]` with the slot full and not being drained: drop the new event, keep the old payload, set `ovf[i]`, and count the drop.
- **Arbiter.** Each cycle, if any `pend[i]` is set and the FIFO can accept, the lowest set index i is written into the FIFO as {i, `pend_data[i]`} and `pend[i]` clears. Only one source is drained per cycle.
- **FIFO can accept** when count < DEPTH, or when count == DEPTH and a valid pop happens the same cycle.
- **Pop.** `irq_ack` while count > 0 pops the head. `irq_ack` while empty is ignored.
- **Simultaneous push and pop** leaves count unchanged. Both pointers wrap modulo DEPTH.
- **Overflow flags.** `ovf_clr` clears all `ovf` bits. A drop in the same cycle as `ovf_clr` wins, so that bit stays set.
- **Reset.** Asserting `rst_n` low at any time, including mid-burst, immediately clears pending slots, pointers, count, `ovf` and `drop_cnt`. All outputs read 0.

## Timing
- An event sampled at edge t is in its pending slot after edge t. It is written to the FIFO at edge t+1 if it wins arbitration and the FIFO can accept.
- `irq`, `irq_data` and `irq_src` are driven from registered FIFO state. An event arriving into an empty, idle queue shows on `irq` in the cycle after edge t+1, i.e. 2 cycles of latency.
- With k simultaneous events into an empty queue, entries are written on edges t+1 .. t+k in ascending source index.
- A pop at edge p updates the head outputs after edge p. If the FIFO empties, `irq` drops after edge p.
- Sustained throughput is one event in and one event out per cycle.

## Configuration
- `IRQQ_DROP_COUNT_EN` defined: `drop_cnt` counts every dropped event, adding the number of drops in the cycle (several sources may drop together) and saturating at 255. `ovf_clr` also clears it.
- `IRQQ_DROP_COUNT_EN` undefined: the counter is not built and `drop_cnt` is tied to 0. The `ovf` flags behave identically in both builds.

## Test plan
1. **Reset state.** Hold `rst_n`=0 then release. Required: `irq`=0, `irq_data`=0, `irq_src`=0, `ovf`=0, `drop_cnt`=0.
2. **Single event, NUM_SRC=2.** Pulse `src_valid`=2'b01 with data 104 at edge t. Required: `irq`=1, `irq_data`=104, `irq_src`=0 after edge t+1. Then `irq_ack` for one cycle. Required: `irq`=0 on the next cycle.
3. **Simultaneous events.** Pulse both sources in the same cycle, source 0 with 103 and source 1 with 0xDEAD. Required: head reads 103/src 0; after one ack, head reads 0xDEAD/src 1; after a second ack, `irq`=0; `ovf`=0.
4. **FIFO full with DEPTH=4 and no acks.**
   - Send 6 events from source 0 spaced 2 cycles apart. Required: 4 entries in the FIFO, the 5th event held in its pending slot, the 6th dropped, `ovf`=2'b01, `drop_cnt`=1.
   - Then ack once. Required: the pending event enters the FIFO and count returns to 4.
5. **Full FIFO with simultaneous push and pop.** With count=4 and a pending event, assert `irq_ack`. Required: the push is accepted in the same cycle, count stays 4, and no drop occurs.
6. **Overflow clear and mid-operation reset.**
   - Drop coincident with `ovf_clr`. Required: the `ovf` bit remains 1.
   - Pulse `rst_n` low while 3 entries are queued. Required: `irq`=0 immediately, without waiting for a clock edge.
